// File: rtl/edge_window_ctrl.sv
// Frame sequencer for a 5x5 edge kernel: four line buffers feed a sliding 5x5 window,
// and the kernel's combinational result is registered out with valid/ready.
module edge_window_ctrl #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_pixel,
    output logic [199:0] window_out,
    input  logic [7:0]   pixel_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_pixel,
    output logic         busy,
    output logic         done
);

    localparam int unsigned AW       = $clog2(IMG_W);
    localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t         state_q;
    logic [11:0]    col_q;
    logic [11:0]    row_q;
    logic           win_pend_q;
    logic [7:0]     lbuf [4][IMG_W];
    logic [AW-1:0]  idx;
    logic           advance;
    logic           accept;
    logic           complete;
    logic           last_pix;
    logic [199:0]   win_next;

    assign idx      = col_q[AW-1:0];
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state_q == StRun) && advance;
    assign accept   = in_valid && in_ready;
    assign complete = (row_q >= 12'd4) && (col_q >= 12'd4);
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Shift each row left; the new right column is the vertical slice at col, oldest on top.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_next[(r*5+c)*8 +: 8] = window_out[(r*5+c+1)*8 +: 8];
            end
        end
        win_next[4*8  +: 8] = lbuf[3][idx];
        win_next[9*8  +: 8] = lbuf[2][idx];
        win_next[14*8 +: 8] = lbuf[1][idx];
        win_next[19*8 +: 8] = lbuf[0][idx];
        win_next[24*8 +: 8] = in_pixel;
    end

    // Line buffers carry no reset: stale contents never reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][idx] <= in_pixel;
            for (int j = 1; j < 4; j++) begin
                lbuf[j][idx] <= lbuf[j-1][idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            win_pend_q <= 1'b0;
            window_out <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                StRun: begin
                    if (accept && last_pix) state_q <= StDrain;
                end
                StDrain: begin
                    // Leave only once the last result has been handed off or never existed.
                    if (!win_pend_q && advance) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                window_out <= win_next;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 12'd1;
                end else begin
                    col_q <= col_q + 12'd1;
                end
            end

            if (advance) begin
                out_valid <= win_pend_q;
                if (win_pend_q) out_pixel <= pixel_in;
                win_pend_q <= accept && complete;
            end
        end
    end

endmodule
